// File: rtl/assoc_dcache.sv
// assoc_dcache: N-way set-associative, write-back, write-allocate data cache.
// Uses true LRU replacement. On halt it writes back every dirty line in set/way
// order, then stores the signed hit-minus-miss counter at HITCNT_ADDR and
// raises flushed.
//
// Ports
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   halt                 datapath halt request (sampled in idle only)
//   dmemREN/dmemWEN      datapath read/write request (both high reads)
//   dmemaddr/dmemstore   datapath byte address / write data
//   dhit/dmemload        request serviced this cycle / read data
//   flushed              flush and counter write complete
//   dREN/dWEN            memory read/write request (never both high)
//   daddr/dstore         memory address / write data
//   dwait/dload          memory busy (0 = word completes) / read data
module assoc_dcache #(
    parameter int unsigned SETS        = 8,
    parameter int unsigned WAYS        = 2,
    parameter int unsigned WORDS       = 2,
    parameter logic [31:0] HITCNT_ADDR = 32'h0000_3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);

    localparam int unsigned OffW = $clog2(WORDS);
    localparam int unsigned IdxW = $clog2(SETS);
    localparam int unsigned TagW = 30 - OffW - IdxW;
    localparam int unsigned WayW = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [OffW-1:0] LastWord = OffW'(WORDS - 1);
    localparam logic [IdxW-1:0] LastSet  = IdxW'(SETS - 1);
    localparam logic [WayW-1:0] LastWay  = WayW'(WAYS - 1);

    typedef enum logic [2:0] {
        StIdle, StWb, StFill, StScan, StFlush, StCntWr, StHalted
    } state_e;

    state_e state_q, state_d;

    // Line storage
    logic [TagW-1:0] tag_q   [SETS][WAYS];
    logic            valid_q [SETS][WAYS];
    logic            dirty_q [SETS][WAYS];
    logic [31:0]     data_q  [SETS][WAYS][WORDS];
    logic [WayW-1:0] age_q   [SETS][WAYS];

    logic [OffW-1:0] wcnt_q, wcnt_d;   // word counter for block transfers
    logic [WayW-1:0] vic_q, vic_d;     // victim way of the pending miss
    logic [IdxW-1:0] idx_q, idx_d;     // index of the pending miss
    logic [TagW-1:0] rtag_q, rtag_d;   // tag of the pending miss
    logic [IdxW-1:0] sset_q, sset_d;   // flush scan pointer
    logic [WayW-1:0] sway_q, sway_d;
    logic [31:0]     cnt_q, cnt_d;     // hit-minus-miss counter

    // Request decode
    logic [OffW-1:0] req_off;
    logic [IdxW-1:0] req_idx;
    logic [TagW-1:0] req_tag;
    logic            req, req_wr;
    logic            unused_byte;

    assign req_off     = dmemaddr[2 +: OffW];
    assign req_idx     = dmemaddr[2 + OffW +: IdxW];
    assign req_tag     = dmemaddr[31 -: TagW];
    assign req         = dmemREN | dmemWEN;
    assign req_wr      = dmemWEN & ~dmemREN;
    assign unused_byte = ^dmemaddr[1:0];

    // Lookup; iterating downward makes the lowest-index way win.
    logic            hit, any_inv;
    logic [WayW-1:0] hit_way, inv_way, lru_way, victim;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WayW'(w);
            end
            if (!valid_q[req_idx][w]) begin
                any_inv = 1'b1;
                inv_way = WayW'(w);
            end
            if (age_q[req_idx][w] == LastWay) begin
                lru_way = WayW'(w);
            end
        end
        victim = any_inv ? inv_way : lru_way;
    end

    // Scan pointer helpers
    logic            scan_last, scan_dirty;
    logic [IdxW-1:0] sset_nxt;
    logic [WayW-1:0] sway_nxt;

    assign scan_last  = (sset_q == LastSet) && (sway_q == LastWay);
    assign scan_dirty = valid_q[sset_q][sway_q] & dirty_q[sset_q][sway_q];
    assign sway_nxt   = (sway_q == LastWay) ? '0 : sway_q + 1'b1;
    assign sset_nxt   = (sway_q == LastWay) ? sset_q + 1'b1 : sset_q;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        vic_d    = vic_q;
        idx_d    = idx_q;
        rtag_d   = rtag_q;
        sset_d   = sset_q;
        sway_d   = sway_q;
        cnt_d    = cnt_q;
        dhit     = 1'b0;
        dmemload = '0;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        unique case (state_q)
            StIdle: begin
                if (halt) begin
                    state_d = StScan;
                    sset_d  = '0;
                    sway_d  = '0;
                end else if (req) begin
                    if (hit) begin
                        dhit     = 1'b1;
                        dmemload = data_q[req_idx][hit_way][req_off];
                        cnt_d    = cnt_q + 32'd1;
                    end else begin
                        cnt_d   = cnt_q - 32'd1;
                        vic_d   = victim;
                        idx_d   = req_idx;
                        rtag_d  = req_tag;
                        wcnt_d  = '0;
                        state_d = (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) ?
                                  StWb : StFill;
                    end
                end
            end
            StWb: begin
                dWEN   = 1'b1;
                daddr  = {tag_q[idx_q][vic_q], idx_q, wcnt_q, 2'b00};
                dstore = data_q[idx_q][vic_q][wcnt_q];
                if (!dwait) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == LastWord) state_d = StFill;
                end
            end
            StFill: begin
                dREN  = 1'b1;
                daddr = {rtag_q, idx_q, wcnt_q, 2'b00};
                if (!dwait) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == LastWord) state_d = StIdle;
                end
            end
            StScan: begin
                if (scan_dirty) begin
                    state_d = StFlush;
                    wcnt_d  = '0;
                end else if (scan_last) begin
                    state_d = StCntWr;
                end else begin
                    sset_d = sset_nxt;
                    sway_d = sway_nxt;
                end
            end
            StFlush: begin
                dWEN   = 1'b1;
                daddr  = {tag_q[sset_q][sway_q], sset_q, wcnt_q, 2'b00};
                dstore = data_q[sset_q][sway_q][wcnt_q];
                if (!dwait) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == LastWord) begin
                        if (scan_last) begin
                            state_d = StCntWr;
                        end else begin
                            state_d = StScan;
                            sset_d  = sset_nxt;
                            sway_d  = sway_nxt;
                        end
                    end
                end
            end
            StCntWr: begin
                dWEN   = 1'b1;
                daddr  = HITCNT_ADDR;
                dstore = cnt_q;
                if (!dwait) state_d = StHalted;
            end
            StHalted: flushed = 1'b1;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
            vic_q   <= '0;
            idx_q   <= '0;
            rtag_q  <= '0;
            sset_q  <= '0;
            sway_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            vic_q   <= vic_d;
            idx_q   <= idx_d;
            rtag_q  <= rtag_d;
            sset_q  <= sset_d;
            sway_q  <= sway_d;
            cnt_q   <= cnt_d;
        end
    end

    // Line array updates: hit (LRU + write), fill, flush dirty clear
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < int'(SETS); s++) begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    tag_q[s][w]   <= '0;
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WayW'(w);
                    for (int d = 0; d < int'(WORDS); d++) begin
                        data_q[s][w][d] <= '0;
                    end
                end
            end
        end else begin
            if ((state_q == StIdle) && !halt && req && hit) begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    if (WayW'(w) == hit_way) begin
                        age_q[req_idx][w] <= '0;
                    end else if (age_q[req_idx][w] < age_q[req_idx][hit_way]) begin
                        age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
                    end
                end
                if (req_wr) begin
                    data_q[req_idx][hit_way][req_off] <= dmemstore;
                    dirty_q[req_idx][hit_way]         <= 1'b1;
                end
            end
            if ((state_q == StFill) && !dwait) begin
                data_q[idx_q][vic_q][wcnt_q] <= dload;
                if (wcnt_q == LastWord) begin
                    tag_q[idx_q][vic_q]   <= rtag_q;
                    valid_q[idx_q][vic_q] <= 1'b1;
                    dirty_q[idx_q][vic_q] <= 1'b0;
                end
            end
            if ((state_q == StFlush) && !dwait && (wcnt_q == LastWord)) begin
                dirty_q[sset_q][sway_q] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_assoc_dcache.sv
// Bench for assoc_dcache: instance a uses default parameters, instance b uses
// SETS=4/WAYS=4/WORDS=4. Memory returns addr ^ 32'hC0DE0000 and completes one
// word every two cycles; every completed transfer is logged.
module tb_assoc_dcache;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct packed {
        int          inst;
        logic        r;
        logic        w;
        logic [31:0] addr;
        logic [31:0] store;
        logic        chk_load;
        logic [31:0] load;
        int          cyc;
        int          xfers;
        logic [31:0] first;
        logic [31:0] last;
    } vec_t;

    logic CLK;
    logic nrst_a, nrst_b;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic        a_halt, a_ren, a_wen, a_dhit, a_flushed, a_dREN, a_dWEN, a_dwait;
    logic [31:0] a_addr, a_store, a_load, a_daddr, a_dstore, a_dload;
    logic        b_halt, b_ren, b_wen, b_dhit, b_flushed, b_dREN, b_dWEN, b_dwait;
    logic [31:0] b_addr, b_store, b_load, b_daddr, b_dstore, b_dload;
    logic [1:0]  a_lat, b_lat;
    xfer_t       a_log[$];
    xfer_t       b_log[$];
    vec_t        vecs[22];
    xfer_t       exp_flush[5];

    assoc_dcache u_a (
        .CLK(CLK), .nRST(nrst_a), .halt(a_halt), .dmemREN(a_ren), .dmemWEN(a_wen),
        .dmemaddr(a_addr), .dmemstore(a_store), .dhit(a_dhit), .dmemload(a_load),
        .flushed(a_flushed), .dREN(a_dREN), .dWEN(a_dWEN), .daddr(a_daddr),
        .dstore(a_dstore), .dwait(a_dwait), .dload(a_dload)
    );

    assoc_dcache #(.SETS(4), .WAYS(4), .WORDS(4)) u_b (
        .CLK(CLK), .nRST(nrst_b), .halt(b_halt), .dmemREN(b_ren), .dmemWEN(b_wen),
        .dmemaddr(b_addr), .dmemstore(b_store), .dhit(b_dhit), .dmemload(b_load),
        .flushed(b_flushed), .dREN(b_dREN), .dWEN(b_dWEN), .daddr(b_daddr),
        .dstore(b_dstore), .dwait(b_dwait), .dload(b_dload)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    assign a_dwait = (a_lat != 2'd1);
    assign b_dwait = (b_lat != 2'd1);
    assign a_dload = a_dREN ? (a_daddr ^ 32'hC0DE_0000) : 32'h0;
    assign b_dload = b_dREN ? (b_daddr ^ 32'hC0DE_0000) : 32'h0;

    always @(posedge CLK) begin
        if (a_dREN && a_dWEN) begin
            n_fail++;
            $display("FAIL a_ren_wen_excl: both high at %0t, required exclusive", $time);
        end
        if (!nrst_a || !(a_dREN || a_dWEN)) a_lat <= 2'd0;
        else if (a_lat == 2'd1) begin
            a_log.push_back({a_dWEN, a_daddr, a_dWEN ? a_dstore : a_dload});
            a_lat <= 2'd0;
        end else a_lat <= a_lat + 2'd1;
    end

    always @(posedge CLK) begin
        if (b_dREN && b_dWEN) begin
            n_fail++;
            $display("FAIL b_ren_wen_excl: both high at %0t, required exclusive", $time);
        end
        if (!nrst_b || !(b_dREN || b_dWEN)) b_lat <= 2'd0;
        else if (b_lat == 2'd1) begin
            b_log.push_back({b_dWEN, b_daddr, b_dWEN ? b_dstore : b_dload});
            b_lat <= 2'd0;
        end else b_lat <= b_lat + 2'd1;
    end

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Issue one request right after a posedge; count non-hit cycles until dhit.
    task automatic do_req(input int inst, input logic r, input logic w, input logic [31:0] addr,
                          input logic [31:0] data, output logic [31:0] load, output int cyc);
        logic done;
        @(posedge CLK);
        #1;
        if (inst == 0) begin
            a_ren = r; a_wen = w; a_addr = addr; a_store = data;
        end else begin
            b_ren = r; b_wen = w; b_addr = addr; b_store = data;
        end
        cyc  = 0;
        load = '0;
        done = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge CLK);
            if ((inst == 0) ? a_dhit : b_dhit) begin
                load = (inst == 0) ? a_load : b_load;
                done = 1'b1;
            end else cyc++;
        end
        @(posedge CLK);
        #1;
        a_ren = 1'b0; a_wen = 1'b0; b_ren = 1'b0; b_wen = 1'b0;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            int          base, n, cyc;
            logic [31:0] ld;
            xfer_t       e0, e1;
            base = (vecs[i].inst == 0) ? a_log.size() : b_log.size();
            do_req(vecs[i].inst, vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].store, ld, cyc);
            n = ((vecs[i].inst == 0) ? a_log.size() : b_log.size()) - base;
            check($sformatf("v%0d cycles", i), 65'(cyc), 65'(vecs[i].cyc));
            check($sformatf("v%0d xfers", i), 65'(n), 65'(vecs[i].xfers));
            if (vecs[i].chk_load) check($sformatf("v%0d load", i), 65'(ld), 65'(vecs[i].load));
            if (vecs[i].xfers > 0 && n > 0) begin
                e0 = (vecs[i].inst == 0) ? a_log[base] : b_log[base];
                e1 = (vecs[i].inst == 0) ? a_log[base + n - 1] : b_log[base + n - 1];
                check($sformatf("v%0d first xfer", i), 65'({e0.we, e0.addr}),
                      65'({1'b0, vecs[i].first}));
                check($sformatf("v%0d last xfer", i), 65'({e1.we, e1.addr}),
                      65'({1'b0, vecs[i].last}));
            end
        end
    endtask

    initial begin
        logic [31:0] ld;
        int          cyc, k;
        xfer_t       e;

        // inst r w addr store chk load cyc xfers first last
        vecs[0]  = '{0, 1, 0, 32'h100, 0, 1, 32'hC0DE0100, 5, 2, 32'h100, 32'h104};
        vecs[1]  = '{0, 1, 0, 32'h104, 0, 1, 32'hC0DE0104, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 0, 32'h200, 0, 1, 32'hC0DE0200, 5, 2, 32'h200, 32'h204};
        vecs[3]  = '{0, 1, 0, 32'h100, 0, 1, 32'hC0DE0100, 0, 0, 0, 0};
        vecs[4]  = '{0, 1, 0, 32'h300, 0, 1, 32'hC0DE0300, 5, 2, 32'h300, 32'h304};
        vecs[5]  = '{0, 1, 0, 32'h100, 0, 1, 32'hC0DE0100, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 1, 32'h200, 32'hDEADBEEF, 0, 0, 5, 2, 32'h200, 32'h204};
        vecs[7]  = '{0, 1, 0, 32'h100, 0, 1, 32'hC0DE0100, 0, 0, 0, 0};
        vecs[8]  = '{0, 1, 1, 32'h104, 32'h11111111, 1, 32'hC0DE0104, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 1, 32'h304, 32'hAAAA0001, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 0, 1, 32'h018, 32'hBBBB0002, 0, 0, 5, 2, 32'h018, 32'h01C};
        vecs[11] = '{0, 1, 0, 32'h018, 0, 1, 32'hBBBB0002, 0, 0, 0, 0};
        vecs[12] = '{0, 1, 0, 32'h304, 0, 1, 32'hAAAA0001, 0, 0, 0, 0};
        vecs[13] = '{1, 1, 0, 32'h018, 0, 1, 32'hC0DE0018, 9, 4, 32'h010, 32'h01C};
        vecs[14] = '{1, 1, 0, 32'h054, 0, 1, 32'hC0DE0054, 9, 4, 32'h050, 32'h05C};
        vecs[15] = '{1, 1, 0, 32'h09C, 0, 1, 32'hC0DE009C, 9, 4, 32'h090, 32'h09C};
        vecs[16] = '{1, 1, 0, 32'h0D0, 0, 1, 32'hC0DE00D0, 9, 4, 32'h0D0, 32'h0DC};
        vecs[17] = '{1, 1, 0, 32'h014, 0, 1, 32'hC0DE0014, 0, 0, 0, 0};
        vecs[18] = '{1, 1, 0, 32'h110, 0, 1, 32'hC0DE0110, 9, 4, 32'h110, 32'h11C};
        vecs[19] = '{1, 1, 0, 32'h010, 0, 1, 32'hC0DE0010, 0, 0, 0, 0};
        vecs[20] = '{1, 1, 0, 32'h050, 0, 1, 32'hC0DE0050, 9, 4, 32'h050, 32'h05C};
        vecs[21] = '{1, 1, 0, 32'h0D8, 0, 1, 32'hC0DE00D8, 0, 0, 0, 0};

        // Counter: 8 hits net of misses by the time of halt.
        exp_flush[0] = {1'b1, 32'h300, 32'hC0DE0300};
        exp_flush[1] = {1'b1, 32'h304, 32'hAAAA0001};
        exp_flush[2] = {1'b1, 32'h018, 32'hBBBB0002};
        exp_flush[3] = {1'b1, 32'h01C, 32'hC0DE001C};
        exp_flush[4] = {1'b1, 32'h3100, 32'd8};

        nrst_a = 1'b0; nrst_b = 1'b0;
        a_halt = 1'b0; a_ren = 1'b0; a_wen = 1'b0; a_addr = '0; a_store = '0;
        b_halt = 1'b0; b_ren = 1'b0; b_wen = 1'b0; b_addr = '0; b_store = '0;
        #2;
        check("reset ctl", 65'({a_dhit, a_flushed, a_dREN, a_dWEN}), 65'(0));
        check("reset daddr/dstore", 65'({a_daddr, a_dstore}), 65'(0));
        check("reset dmemload", 65'(a_load), 65'(0));
        check("reset b ctl", 65'({b_dhit, b_flushed, b_dREN, b_dWEN}), 65'(0));
        @(negedge CLK);
        nrst_a = 1'b1; nrst_b = 1'b1;

        // Cold fill, LRU, dirty line creation
        run_vecs(0, 7);

        // Dirty eviction: write back 0x200 line, then fill 0x300
        k = a_log.size();
        do_req(0, 1'b1, 1'b0, 32'h300, 32'h0, ld, cyc);
        check("wb cycles", 65'(cyc), 65'(9));
        check("wb load", 65'(ld), 65'(32'hC0DE0300));
        check("wb xfers", 65'(a_log.size() - k), 65'(4));
        if (a_log.size() - k == 4) begin
            check("wb x0", a_log[k],     {1'b1, 32'h200, 32'hDEADBEEF});
            check("wb x1", a_log[k + 1], {1'b1, 32'h204, 32'hC0DE0204});
            check("wb x2", a_log[k + 2], {1'b0, 32'h300, 32'hC0DE0300});
            check("wb x3", a_log[k + 3], {1'b0, 32'h304, 32'hC0DE0304});
        end

        // REN+WEN hit, dirty lines in set 0 way 1 and set 3 way 0
        run_vecs(8, 12);

        // halt with REN in idle: no hit, then flush
        @(posedge CLK);
        #1;
        a_log.delete();
        a_halt = 1'b1; a_ren = 1'b1; a_addr = 32'h100;
        @(negedge CLK);
        check("halt+ren dhit", 65'(a_dhit), 65'(0));
        @(posedge CLK);
        #1;
        a_halt = 1'b0; a_ren = 1'b0;
        cyc = 0;
        while (!a_flushed && cyc < 300) begin
            @(negedge CLK);
            cyc++;
        end
        check("flushed", 65'(a_flushed), 65'(1));
        check("flush xfers", 65'(a_log.size()), 65'(5));
        for (int i = 0; i < 5; i++) begin
            e = (i < a_log.size()) ? a_log[i] : '0;
            check($sformatf("flush x%0d", i), e, exp_flush[i]);
        end
        a_ren = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("halted hold %0d", i),
                  65'({a_flushed, a_dhit, a_dREN, a_dWEN}), 65'(4'b1000));
        end
        a_ren = 1'b0;

        // Reset during write-back
        @(negedge CLK);
        nrst_a = 1'b0;
        @(negedge CLK);
        nrst_a = 1'b1;
        do_req(0, 1'b0, 1'b1, 32'h100, 32'h12345678, ld, cyc);
        check("rst pre write cycles", 65'(cyc), 65'(5));
        do_req(0, 1'b1, 1'b0, 32'h200, 32'h0, ld, cyc);
        check("rst pre read cycles", 65'(cyc), 65'(5));
        @(posedge CLK);
        #1;
        a_ren = 1'b1; a_addr = 32'h300;
        cyc = 0;
        while (!a_dWEN && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        check("wb started", 65'(a_dWEN), 65'(1));
        #2;
        nrst_a = 1'b0;
        #1;
        check("rst mid wb ctl", 65'({a_dhit, a_flushed, a_dREN, a_dWEN}), 65'(0));
        check("rst mid wb bus", 65'({a_daddr, a_dstore}), 65'(0));
        a_ren = 1'b0;
        @(negedge CLK);
        nrst_a = 1'b1;
        do_req(0, 1'b1, 1'b0, 32'h100, 32'h0, ld, cyc);
        check("post rst miss cycles", 65'(cyc), 65'(5));
        check("post rst load", 65'(ld), 65'(32'hC0DE0100));

        // Four-way, four-word variant
        run_vecs(13, 21);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/assoc_dcache.md
# assoc_dcache

Parameterised N-way set-associative, write-back, write-allocate data cache between the datapath memory port and the memory arbiter. It generalises the fixed 8-set/2-way/2-word dcache in set count, associativity and block size, and uses true LRU replacement. On `halt` it flushes every dirty line, then writes a signed hit-minus-miss counter to a fixed address and asserts `flushed`.

## Interface
- `SETS`, 8, number of sets; power of 2, ≥2.
- `WAYS`, 2, associativity; power of 2, 1..8.
- `WORDS`, 2, 32-bit words per block; power of 2, ≥2.
- `HITCNT_ADDR`, 32'h0000_3100, word address written with the hit counter after flush.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `halt` in 1: datapath halt request.
- `dmemREN` in 1: datapath read request.
- `dmemWEN` in 1: datapath write request.
- `dmemaddr` in 32: byte address, word aligned.
- `dmemstore` in 32: write data.
- `dhit` out 1: request serviced this cycle.
- `dmemload` out 32: read data, valid when `dhit`.
- `flushed` out 1: flush and counter write are complete.
- `dREN` out 1: memory read request.
- `dWEN` out 1: memory write request.
- `daddr` out 32: memory word address.
- `dstore` out 32: memory write data.
- `dwait` in 1: memory busy; 0 means the current word completes this cycle.
- `dload` in 32: memory read data, valid when `dwait` is 0.

## Operation
- Address split: [1:0] byte (ignored); next log2(WORDS) bits are the word offset; next log2(SETS) bits are the index; the remainder is the tag.
- Line state per way: tag, valid, dirty, WORDS data words, LRU age of log2(WAYS) bits. Age 0 means most recently used.
- FSM states: IDLE, WB, FILL, SCAN, FLUSH, CNTWR, HALTED.
- IDLE, `halt`=1: go to SCAN. `dhit`=0 and no request is serviced, even if REN/WEN is also asserted.
- IDLE, REN or WEN, tag match on a valid way (hit): `dhit`=1 combinationally in the same cycle.
  - Read: `dmemload` = the addressed word.
  - Write: the word is updated at the clock edge and the line's dirty bit is set.
  - The hit way's age becomes 0. Ways whose age was less than the hit way's old age increment by 1.
  - The counter increments by 1.
- REN and WEN both asserted: treat as a read.
- Miss:
  - Victim is the lowest-index invalid way; if every way is valid, the way with age WAYS-1.
  - The counter decrements by 1.
  - Go to WB if the victim is valid and dirty, else to FILL.
- WB: `dWEN`=1. `daddr` = {victim tag, index, word counter, 2'b00}. `dstore` = victim word. The word counter advances on `dwait`=0. After the last word, go to FILL.
- FILL: `dREN`=1. `daddr` = {request tag, index, word counter, 2'b00}. `dload` is written into the victim on `dwait`=0. After the last word: set tag and valid, clear dirty, return to IDLE.
  - The retried request then hits and increments the counter, so a cold miss nets 0.
  - The victim's LRU ages are unchanged until that hit.
- SCAN: visit lines in order set 0 way 0, set 0 way 1, …, set SETS-1 way WAYS-1, one cycle per line.
  - Dirty valid line: go to FLUSH.
  - Otherwise advance to the next line. After the last line, go to CNTWR.
- FLUSH: write WORDS words as in WB. Then clear the dirty bit and return to SCAN at the next line.
- CNTWR: `dWEN`=1, `daddr`=HITCNT_ADDR, `dstore`=counter. On `dwait`=0, go to HALTED.
- HALTED: `flushed`=1. Requests are ignored. The block stays here until reset.
- Counter: 32-bit two's complement; wraps on overflow and underflow.
- `dREN` and `dWEN` are never asserted together.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - All valid, dirty and data bits 0; counter 0.
  - Way w's age = w mod WAYS.
- Hit latency: 0 cycles (combinational `dhit`).
- Miss latency, clean victim: 1 decision cycle + WORDS memory transfers, then the hit cycle.
- Miss latency, dirty victim: add WORDS memory transfers.
- Outside IDLE, `dhit`=0 and `dmemload`=0.
- Memory outputs are held stable while `dwait`=1.
- `nRST` asserted mid-transfer: the transfer is abandoned. All lines are invalid and `dREN`/`dWEN` drop asynchronously.
- Halt while a miss is in progress: the miss completes first. `halt` is sampled only in IDLE.

## Test plan
- Cold read, default params (`dwait` low 2 cycles per word): read 0x100 → `dREN` at 0x100 then 0x104. After the fill, `dhit`=1 and `dmemload` = word returned for 0x100. Counter 0.
- LRU (all map to set 0): read 0x100, read 0x200, read 0x100, then read 0x300 → 0x200's way is replaced. Read 0x100 still hits with no memory traffic.
- Dirty eviction: write 0x200←0xDEADBEEF, then read 0x100 and 0x300 → WB writes 0x200=0xDEADBEEF and 0x204=old word, then FILL of 0x300/0x304.
- Halt flush: dirty lines in set 0 way 1 and set 3 way 0 → writes in order set 0 then set 3. Then a write to 0x3100 with the counter value. `flushed`=1 and held.
- Simultaneous events: REN+WEN on a hit reads without dirtying. `halt`+REN in IDLE gives `dhit`=0 and goes to SCAN. Reset during WB leaves all outputs 0 and the next read misses.
- Parameter variant SETS=4, WAYS=4, WORDS=4: four-word fills, correct index/offset slicing, and a 5th conflicting tag evicts the least-recently-used way.
